dp_block_ram_be: RTL
====================

DP_BLOCK_RAM_BE -- requirements
Module: dp_block_ram_be

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- W_DATA, 128, data width in bits; multiple of 8.
- N_CELL, 1024, number of words.
- W_CELL, 10, address width; 2^W_CELL >= N_CELL.
- N_DELAY, 1, read latency in cycles; legal range 1..4.
- RDW_MODE, 0, same-address read-during-write: 0 = old data, 1 = new data.
- CLR_ON_RST, 1, 1 = zero the whole array after reset.
- FILENAME, "", hex init file for simulation only; ignored when empty.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on its rising edge.
- rstn, in, 1, reset; synchronous, active-low.
- ena, in, 1, port A (write) enable.
- wea, in, W_DATA/8, per-byte write enable; bit i covers dia[8i+7:8i].
- addra, in, W_CELL, write address.
- dia, in, W_DATA, write data.
- enb, in, 1, port B (read) enable.
- addrb, in, W_CELL, read address.
- dob, out, W_DATA, read data.
- dob_vld, out, 1, dob holds data for a read issued N_DELAY cycles earlier.
- clr_req, in, 1, single-cycle request to zero the whole array.
- busy, out, 1, clear in progress; port accesses ignored.

Function
REQ-003 A write SHALL occur when ena=1, busy=0 and addra<N_CELL; only bytes with wea[i]=1 are updated; the other bytes keep their value.
REQ-004 A write with addra>=N_CELL SHALL be dropped with no side effect.
REQ-005 A read SHALL be accepted when enb=1 and busy=0; its data appears on dob with dob_vld=1 exactly N_DELAY cycles later.
REQ-006 The read pipeline SHALL advance every cycle regardless of enb; a valid bit travels with each stage.
REQ-007 When a stage's valid bit is 0, dob SHALL hold its previous value and dob_vld SHALL be 0.
REQ-008 A read with addrb>=N_CELL SHALL return all zeros with dob_vld=1.
REQ-009 For an accepted read and write in the same cycle at the same address, RDW_MODE=0 SHALL return pre-write data; RDW_MODE=1 SHALL return the merged word (new bytes where wea=1, old bytes elsewhere).
REQ-010 The clear FSM SHALL have two states, IDLE and CLEAR, with a W_CELL-bit counter clr_addr.
REQ-011 In IDLE, clr_req=1 SHALL go to CLEAR with clr_addr=0.
REQ-012 In CLEAR, one word per cycle SHALL be written to zero at clr_addr, then clr_addr increments.
REQ-013 In CLEAR, after writing clr_addr=N_CELL-1 the FSM SHALL return to IDLE; a clear takes exactly N_CELL cycles.
REQ-014 busy SHALL equal 1 exactly while in CLEAR, and SHALL be a registered output.
REQ-015 clr_req while in CLEAR SHALL be ignored; it does not restart the clear.
REQ-016 ena and enb while busy=1 SHALL be ignored; no valid bit enters the read pipeline.
REQ-017 Reads already in flight when a clear starts SHALL complete with their pre-clear data.
REQ-018 After any write to an address, a read issued on a later cycle SHALL return the written data, with no extra hazard cycles.

Reset
REQ-019 While rstn=0 at a clock edge, the block SHALL set dob=0, dob_vld=0 and all pipeline valid bits to 0, and SHALL perform no array writes.
REQ-020 On the first edge with rstn=1, if CLR_ON_RST=1 the FSM SHALL be in CLEAR with clr_addr=0 and busy=1.
REQ-021 If CLR_ON_RST=0, the FSM SHALL be in IDLE with busy=0 after reset.
REQ-022 Reset asserted during CLEAR SHALL restart the clear from address 0 when CLR_ON_RST=1, or abort it when CLR_ON_RST=0.
REQ-023 The array itself SHALL NOT be reset except through the clear FSM.

Verification
REQ-024 Test config W_DATA=32, N_CELL=16, W_CELL=5, N_DELAY=3, CLR_ON_RST=1. Release reset -> busy=1 for exactly 16 cycles; read all 16 addresses -> each returns 0x00000000 with dob_vld 3 cycles after the request.
REQ-025 Write 0xAABBCCDD to addr 5 with wea=4'b1111, then 0x11223344 with wea=4'b0101 -> read addr 5 returns 0xAA22CC44.
REQ-026 Same-cycle write 0x12345678 (wea all ones) and read at addr 3, which holds 0 -> RDW_MODE=0 returns 0x00000000; RDW_MODE=1 returns 0x12345678.
REQ-027 Back-to-back reads of addrs 0..4 on consecutive cycles, then enb=0 -> five consecutive dob_vld pulses in order, then dob_vld=0 with dob held at the addr-4 data.
REQ-028 Write addr 20 (out of range), then read addr 20 and addr 4 -> addr 20 returns 0 with dob_vld=1; addr 4 is unchanged.
REQ-029 Pulse clr_req, pulse rstn=0 at the 7th busy cycle, then release -> busy=1 for exactly 16 more cycles; ena/enb during busy have no effect; all words read 0 afterwards.

Source files
------------

// File: rtl/dp_block_ram_be.sv
// Dual-port block RAM: byte-enable write port A, pipelined read port B.
// Ports: clk/rstn, A (ena,wea,addra,dia), B (enb,addrb,dob,dob_vld), clr_req/busy.
module dp_block_ram_be #(
  parameter int    W_DATA     = 128,
  parameter int    N_CELL     = 1024,
  parameter int    W_CELL     = 10,
  parameter int    N_DELAY    = 1,
  parameter int    RDW_MODE   = 0,
  parameter int    CLR_ON_RST = 1,
  parameter string FILENAME   = ""
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                ena,
  input  logic [W_DATA/8-1:0] wea,
  input  logic [W_CELL-1:0]   addra,
  input  logic [W_DATA-1:0]   dia,
  input  logic                enb,
  input  logic [W_CELL-1:0]   addrb,
  output logic [W_DATA-1:0]   dob,
  output logic                dob_vld,
  input  logic                clr_req,
  output logic                busy
);

  localparam int NB  = W_DATA / 8;
  localparam int AW  = (N_CELL > 1) ? $clog2(N_CELL) : 1;
  localparam int WC1 = W_CELL + 1;
  localparam logic [W_CELL:0]   NC   = WC1'(N_CELL);
  localparam logic [W_CELL-1:0] LAST = W_CELL'(N_CELL - 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } st_t;

  localparam st_t ST_RST = (CLR_ON_RST != 0) ? CLEAR : IDLE;

  st_t               st_q, st_d;
  logic [W_CELL-1:0] clr_addr_q, clr_addr_d;
  logic              busy_q, busy_d;

  logic [W_DATA-1:0] mem [N_CELL];

  logic              a_in, b_in;
  logic              wr_ok, rd_ok;
  logic [W_DATA-1:0] rd_word;

  logic [W_DATA-1:0]  pd_q [N_DELAY];
  logic [W_DATA-1:0]  pd_d [N_DELAY];
  logic [N_DELAY-1:0] pv_q, pv_d;

  assign a_in  = {1'b0, addra} < NC;
  assign b_in  = {1'b0, addrb} < NC;
  assign wr_ok = ena & ~busy_q & a_in;
  assign rd_ok = enb & ~busy_q;

  // Read word captured at accept time; bypass merges the
  // concurrent write when new-data mode is selected.
  always_comb begin
    rd_word = '0;
    if (b_in) begin
      rd_word = mem[addrb[AW-1:0]];
      if (RDW_MODE != 0 && wr_ok && addra == addrb) begin
        for (int i = 0; i < NB; i++) begin
          if (wea[i]) rd_word[8*i +: 8] = dia[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    st_d       = st_q;
    clr_addr_d = clr_addr_q;
    unique case (st_q)
      IDLE: begin
        if (clr_req) begin
          st_d       = CLEAR;
          clr_addr_d = '0;
        end
      end
      CLEAR: begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == LAST) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
    busy_d = (st_d == CLEAR);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      st_q       <= ST_RST;
      clr_addr_q <= '0;
      busy_q     <= (CLR_ON_RST != 0);
    end else begin
      st_q       <= st_d;
      clr_addr_q <= clr_addr_d;
      busy_q     <= busy_d;
    end
  end

  // Array has no reset; only the clear FSM zeroes it.
  always_ff @(posedge clk) begin
    if (rstn) begin
      if (st_q == CLEAR) begin
        mem[clr_addr_q[AW-1:0]] <= '0;
      end else if (wr_ok) begin
        for (int i = 0; i < NB; i++) begin
          if (wea[i]) mem[addra[AW-1:0]][8*i +: 8] <= dia[8*i +: 8];
        end
      end
    end
  end

  // Each stage only loads data when a valid entry arrives,
  // so the output holds between reads.
  always_comb begin
    pv_d[0] = rd_ok;
    pd_d[0] = rd_ok ? rd_word : pd_q[0];
    for (int k = 1; k < N_DELAY; k++) begin
      pv_d[k] = pv_q[k-1];
      pd_d[k] = pv_q[k-1] ? pd_q[k-1] : pd_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pv_q <= '0;
      for (int k = 0; k < N_DELAY; k++) pd_q[k] <= '0;
    end else begin
      pv_q <= pv_d;
      for (int k = 0; k < N_DELAY; k++) pd_q[k] <= pd_d[k];
    end
  end

  assign dob     = pd_q[N_DELAY-1];
  assign dob_vld = pv_q[N_DELAY-1];
  assign busy    = busy_q;

endmodule
